// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter state encoding and the BAUD clamp rule.
package mmio_uart_tx_pkg;

    // Word-offset register select (Addr[3:2])
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_COUNT_LSB = 4;

    localparam logic [15:0] BAUD_MIN = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // A divider below 2 cannot produce a meaningful bit period.
    function automatic logic [15:0] clamp_baud(input logic [15:0] v);
        return (v < BAUD_MIN) ? BAUD_MIN : v;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with one extra pointer bit for full/empty disambiguation.
// Push is dropped when full and pop ignored when empty, both judged pre-edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO,
// baud counter and start/data/stop framing state machine.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int BAUD_DIV_RST = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Sel,
    input  logic                  Mem_Write,
    input  logic [3:0]            Addr,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  TX,
    output logic                  TX_Empty
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus handshake: a store is accepted on every rising edge where
    // Sel & Mem_Write is high; there is no ready/stall, the window never
    // back-pressures. Loads are combinational and side-effect free.
    logic       wr_en;
    logic [1:0] reg_sel;
    assign wr_en   = Sel & Mem_Write;
    assign reg_sel = Addr[3:2];

    logic          unused_bits;
    assign unused_bits = ^{Addr[1:0], Write_Data[DATA_WIDTH-1:16]};

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] frame_baud_q, frame_baud_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        en_q, en_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          busy, can_start, load_frame;

    assign fifo_push = wr_en && (reg_sel == REG_TXDATA);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (fifo_push),
        .wdata (Write_Data[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin : reg_comb
        baud_d = baud_q;
        en_d   = en_q;
        if (wr_en) begin
            case (reg_sel)
                REG_BAUD: baud_d = clamp_baud(Write_Data[15:0]);
                REG_CTRL: en_d   = Write_Data[0];
                default:  ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign can_start = en_q & ~fifo_empty;

    always_comb begin : fsm_comb
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        frame_baud_d = frame_baud_q;
        fifo_pop     = 1'b0;
        load_frame   = 1'b0;
        case (state_q)
            S_IDLE: load_frame = can_start;
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = frame_baud_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = frame_baud_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                // The last stop cycle may hand straight over to the next frame.
                if (cnt_q == 16'd0) begin
                    state_d    = S_IDLE;
                    load_frame = can_start;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The divider is latched here so mid-frame BAUD writes wait for the next frame.
        if (load_frame) begin
            fifo_pop     = 1'b1;
            shift_d      = fifo_rdata;
            frame_baud_d = baud_q;
            cnt_d        = baud_q - 16'd1;
            state_d      = S_START;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            baud_q       <= 16'(BAUD_DIV_RST);
            frame_baud_q <= 16'(BAUD_DIV_RST);
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            frame_baud_q <= frame_baud_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            en_q         <= en_d;
        end
    end

    // Decoded from state so an async reset forces the line high at once.
    always_comb begin : tx_comb
        case (state_q)
            S_START: TX = 1'b0;
            S_DATA:  TX = shift_q[0];
            default: TX = 1'b1;
        endcase
    end

    assign TX_Empty = fifo_empty & ~busy;

    always_comb begin : read_comb
        Read_Data = '0;
        if (Sel) begin
            case (reg_sel)
                REG_STATUS: begin
                    Read_Data[STAT_COUNT_LSB +: 4] = 4'(fifo_count);
                    Read_Data[STAT_BUSY_BIT]       = busy;
                    Read_Data[STAT_FULL_BIT]       = fifo_full;
                    Read_Data[STAT_EMPTY_BIT]      = fifo_empty;
                end
                REG_BAUD: Read_Data[15:0] = baud_q;
                REG_CTRL: Read_Data[0]    = en_q;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a waveform-queue model of the serial line
// checked every cycle, plus literal expectations for framing and registers.
module tb_mmio_uart_tx;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_BAUD   = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'hC;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel, mem_write;
  logic [3:0]    addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          tx, tx_empty;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_uart_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(434)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Sel        (sel),
    .Mem_Write  (mem_write),
    .Addr       (addr),
    .Write_Data (wdata),
    .Read_Data  (rdata),
    .TX         (tx),
    .TX_Empty   (tx_empty)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_wave holds the line level for the current cycle and every cycle still owed
  // by the frame in flight; an empty queue means the transmitter is idle.
  logic [7:0]  m_fifo[$];
  logic        m_wave[$];
  logic [15:0] m_baud = 16'd434;
  logic        m_en = 1'b0;
  logic        m_push_ok;
  logic [7:0]  m_byte;
  logic [9:0]  m_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_wave.delete();
      m_baud = 16'd434;
      m_en   = 1'b0;
    end else begin
      m_push_ok = sel && mem_write && (addr[3:2] == 2'd0) && (m_fifo.size() < DEPTH);
      if (m_wave.size() > 0) void'(m_wave.pop_front());
      if (m_wave.size() == 0 && m_en && m_fifo.size() > 0) begin
        m_byte  = m_fifo.pop_front();
        m_frame = {1'b1, m_byte, 1'b0};
        for (int s = 0; s < 10; s++)
          for (int c = 0; c < int'(m_baud); c++) m_wave.push_back(m_frame[s]);
      end
      if (m_push_ok) m_fifo.push_back(wdata[7:0]);
      if (sel && mem_write && addr[3:2] == 2'd2)
        m_baud = (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      if (sel && mem_write && addr[3:2] == 2'd3) m_en = wdata[0];
    end
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(m_fifo.size()) << 4;
    s[2] = (m_wave.size() != 0);
    s[1] = (m_fifo.size() == DEPTH);
    s[0] = (m_fifo.size() == 0);
    return s;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every cycle out of reset the line and the empty flag must follow the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("line_tx", {31'b0, tx}, {31'b0, (m_wave.size() != 0) ? m_wave[0] : 1'b1});
      check("line_tx_empty", {31'b0, tx_empty},
            {31'b0, (m_fifo.size() == 0) && (m_wave.size() == 0)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; mem_write = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; mem_write = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
    sel = 1'b0;
  endtask

  task automatic wait_tx_low();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 3000);
    if (tx !== 1'b0) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_tx_low: got timeout, expected start bit within 3000 cycles");
    end
  endtask

  // Cycles from the first start-bit cycle until TX_Empty rises.
  task automatic measure_busy(output int n);
    wait_tx_low();
    n = 0;
    while (tx_empty !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Receive one frame at BAUD=4, sampling mid-bit.
  task automatic rx_byte(output logic [7:0] b);
    wait_tx_low();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    check("rx_stop_bit", {31'b0, tx}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int          len;
  logic [7:0]  rx_b;
  logic [9:0]  pat;
  logic [7:0]  exp_bytes[3];

  initial begin
    rst_n = 1'b0; sel = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("reset_tx_in_reset", {31'b0, tx}, 32'd1);
    rst_n = 1'b1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_tx_empty", {31'b0, tx_empty}, 32'd1);
    bus_read_check("reset_status", A_STATUS, 32'h1);
    bus_read_check("reset_baud", A_BAUD, 32'd434);
    bus_read_check("reset_ctrl", A_CTRL, 32'd0);
    bus_read_check("txdata_reads_zero", A_TXDATA, 32'd0);
    @(negedge clk);
    sel = 1'b0; addr = A_BAUD; #1;
    check("unselected_read_zero", rdata, 32'd0);

    // 2: single 0x55 frame at BAUD=4
    bus_write(A_BAUD, 32'd4);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h55);
    wait_tx_low();
    pat = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      check("frame55_wave", {31'b0, tx}, {31'b0, pat[j/4]});
      @(negedge clk);
    end
    check("frame55_done", {31'b0, tx_empty}, 32'd1);

    // 3: fill while disabled, overflow dropped, then four back-to-back frames
    bus_write(A_CTRL, 32'd0);
    for (int k = 1; k <= 5; k++) bus_write(A_TXDATA, 32'(k));
    bus_read_check("full_status", A_STATUS, 32'h42);
    bus_read_check("full_status_model", A_STATUS, model_status());
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h66);  // lands on the first pop edge while full: dropped
    measure_busy(len);
    check("four_frames_clks", 32'(len), 32'd160);
    bus_read_check("drained_status", A_STATUS, 32'h1);

    // 4: BAUD clamp and mid-frame BAUD write
    bus_write(A_BAUD, 32'd0);
    bus_read_check("baud_clamp0", A_BAUD, 32'd2);
    bus_write(A_BAUD, 32'd1);
    bus_read_check("baud_clamp1", A_BAUD, 32'd2);
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'h96);
    fork
      measure_busy(len);
      begin
        repeat (12) @(negedge clk);
        bus_write(A_BAUD, 32'd8);
      end
    join
    check("midframe_baud_len", 32'(len), 32'd40);
    bus_read_check("baud_readback8", A_BAUD, 32'd8);
    bus_write(A_TXDATA, 32'h69);
    measure_busy(len);
    check("next_frame_baud8_len", 32'(len), 32'd80);

    // 5: reset during data bit 3
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'hA3);
    bus_write(A_TXDATA, 32'h3C);
    bus_write(A_TXDATA, 32'h0F);
    wait_tx_low();
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'd1);
    check("async_reset_tx_empty", {31'b0, tx_empty}, 32'd1);
    sel = 1'b1; addr = A_STATUS; #1;
    check("async_reset_status", rdata, 32'h1);
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_reset_idle_tx", {31'b0, tx}, 32'd1);
    bus_read_check("post_reset_status", A_STATUS, 32'h1);
    bus_read_check("post_reset_ctrl", A_CTRL, 32'd0);
    bus_read_check("post_reset_baud", A_BAUD, 32'd434);

    // 6: push on the same edge as an IDLE pop with two entries queued
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TXDATA, 32'h11);
    bus_write(A_TXDATA, 32'h22);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_TXDATA, 32'h33);
    bus_read_check("push_pop_status", A_STATUS, 32'h24);
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      rx_byte(rx_b);
      check("rx_order", {24'b0, rx_b}, {24'b0, exp_bytes[k]});
    end
    repeat (10) @(negedge clk);
    check("final_tx_empty", {31'b0, tx_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    tests_failed++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

endmodule
